// File: rtl/mem_rwport_if.sv
// Single-ported memory read/write bus: one request (addr/wdata/wen/val)
// answered by rdy in the same cycle, read data one cycle later.
interface mem_rwport;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wen;
  logic        val;
  logic [15:0] rdata;
  logic        rdy;

  modport master (output addr, wdata, wen, val, input rdata, rdy);
  modport slave  (input addr, wdata, wen, val, output rdata, rdy);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory rw port between NREQ requesters.
// Blocks all traffic during the post-reset memory clear window, supports a
// per-requester lock for atomic sequences, and tags 1-cycle read data back
// to its issuer.
module mem_arbiter #(
  parameter int NREQ        = 3,
  parameter int INIT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,     // active-high asynchronous reset
  mem_rwport.slave        req_intf [NREQ],
  input  logic [NREQ-1:0] req_lock_i,
  output logic [NREQ-1:0] rd_vld_o,
  mem_rwport.master       mem_intf,
  output logic            init_done_o
);

  localparam int CW = $clog2(INIT_CYCLES) + 1;
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        wen;
  } req_t;

  req_t [NREQ-1:0] rq;
  logic [NREQ-1:0] val;
  logic [NREQ-1:0] rdy;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic [TW-1:0]   last_q, last_d;
  logic            lock_vld_q, lock_vld_d;
  logic [TW-1:0]   lock_own_q, lock_own_d;
  logic            pend_vld_q, pend_vld_d;
  logic [TW-1:0]   pend_tag_q, pend_tag_d;

  logic            gnt_vld;
  logic [TW-1:0]   gnt_idx;
  logic            acc;

  // Flatten the requester interface array; read data is broadcast to all.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign val[gi]              = req_intf[gi].val;
    assign rq[gi]               = {req_intf[gi].addr, req_intf[gi].wdata, req_intf[gi].wen};
    assign req_intf[gi].rdy     = rdy[gi];
    assign req_intf[gi].rdata   = mem_intf.rdata;
  end

  // Pick the grant: a lock owner still asserting val wins, else round-robin
  // starting just after the last accepted requester (wrap modulo NREQ).
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == S_RUN) begin
      if (lock_vld_q && val[lock_own_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_own_q;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = int'(last_q) + k;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!gnt_vld && val[TW'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_idx = TW'(idx);
          end
        end
      end
    end
  end

  assign acc            = gnt_vld && mem_intf.rdy;
  assign mem_intf.val   = gnt_vld;
  assign mem_intf.addr  = gnt_vld ? rq[gnt_idx].addr  : '0;
  assign mem_intf.wdata = gnt_vld ? rq[gnt_idx].wdata : '0;
  assign mem_intf.wen   = gnt_vld ? rq[gnt_idx].wen   : 1'b0;
  assign init_done_o    = init_done_q;

  // Only the granted requester sees memory rdy; read tag decodes to one-hot.
  always_comb begin
    rdy               = '0;
    rdy[gnt_idx]      = acc;
    rd_vld_o          = '0;
    rd_vld_o[pend_tag_q] = pend_vld_q;
  end

  // Next-state: init window, pointer/lock/pending updates on acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    lock_vld_d  = lock_vld_q;
    lock_own_d  = lock_own_q;
    pend_vld_d  = 1'b0;
    pend_tag_d  = pend_tag_q;
    if (state_q == S_INIT) begin
      if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(INIT_CYCLES - 1)) begin
        state_d     = S_RUN;
        init_done_d = 1'b1;
      end
    end
    // Owner dropping val releases the lock so the port never idles on it.
    if (lock_vld_q && !val[lock_own_q]) lock_vld_d = 1'b0;
    if (acc) begin
      last_d     = gnt_idx;
      lock_vld_d = req_lock_i[gnt_idx];
      lock_own_d = gnt_idx;
      if (!rq[gnt_idx].wen) begin
        pend_vld_d = 1'b1;
        pend_tag_d = gnt_idx;
      end
    end
  end

  // State registers; reset parks the pointer at NREQ-1 so requester 0 leads.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      last_q      <= TW'(NREQ - 1);
      lock_vld_q  <= 1'b0;
      lock_own_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
      lock_vld_q  <= lock_vld_d;
      lock_own_q  <= lock_own_d;
      pend_vld_q  <= pend_vld_d;
      pend_tag_q  <= pend_tag_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-requester op tables drive the ports,
// expected grants and read returns are queued, a monitor checks them.
module tb_mem_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] r_val = '0, r_wen = '0, r_lock = '0;
  logic [7:0]   r_addr  [N];
  logic [15:0]  r_wdata [N];
  logic [N-1:0] rdy_w;
  logic [15:0]  rdata_w [N];
  logic [N-1:0] rd_vld;
  logic         init_done;
  logic         m_rdy = 1'b1;
  logic [15:0]  m_rdata;
  logic [15:0]  mem [256];

  mem_rwport req_if [N] ();
  mem_rwport mem_if ();

  for (genvar gi = 0; gi < N; gi++) begin : g_if
    assign req_if[gi].addr  = r_addr[gi];
    assign req_if[gi].wdata = r_wdata[gi];
    assign req_if[gi].wen   = r_wen[gi];
    assign req_if[gi].val   = r_val[gi];
    assign rdy_w[gi]        = req_if[gi].rdy;
    assign rdata_w[gi]      = req_if[gi].rdata;
  end
  assign mem_if.rdy   = m_rdy;
  assign mem_if.rdata = m_rdata;

  mem_arbiter #(.NREQ(N), .INIT_CYCLES(256)) dut (
    .clk_i(clk), .rst_ni(rst), .req_intf(req_if), .req_lock_i(r_lock),
    .rd_vld_o(rd_vld), .mem_intf(mem_if), .init_done_o(init_done));

  // Main memory model: clears on reset, 1-cycle read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      m_rdata <= '0;
    end else if (mem_if.val && m_rdy) begin
      if (mem_if.wen) mem[mem_if.addr] <= mem_if.wdata;
      else            m_rdata <= mem[mem_if.addr];
    end
  end

  typedef struct { logic [7:0] addr; logic [15:0] wdata; logic wen; logic lock; } op_t;
  typedef struct { int req; logic [7:0] addr; logic wen; } g_t;
  typedef struct { logic [N-1:0] vld; logic [15:0] data; } r_t;

  op_t tbl [N][16];
  int  cnt [N];
  int  pos [N];
  bit  acc_s [N];
  g_t  gq [$];
  r_t  rq [$];
  int  checks = 0;
  int  errors = 0;

  initial for (int i = 0; i < N; i++) begin cnt[i] = 0; pos[i] = 0; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_op(input int r, input logic [7:0] a, input logic [15:0] d,
                         input logic w, input logic l);
    tbl[r][cnt[r]] = '{addr: a, wdata: d, wen: w, lock: l};
    cnt[r]++;
  endtask

  task automatic exp_g(input int r, input logic [7:0] a, input logic w);
    gq.push_back('{req: r, addr: a, wen: w});
  endtask

  task automatic exp_r(input logic [N-1:0] v, input logic [15:0] d);
    rq.push_back('{vld: v, data: d});
  endtask

  // Requester driver: hold the head op until accepted, then advance.
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) acc_s[i] = r_val[i] && rdy_w[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_s[i]) pos[i]++;
      if (pos[i] < cnt[i]) begin
        r_val[i]   = 1'b1;
        r_addr[i]  = tbl[i][pos[i]].addr;
        r_wdata[i] = tbl[i][pos[i]].wdata;
        r_wen[i]   = tbl[i][pos[i]].wen;
        r_lock[i]  = tbl[i][pos[i]].lock;
      end else begin
        r_val[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_wen[i] = 1'b0; r_lock[i] = 1'b0;
      end
    end
  end

  // Monitor: compare every acceptance and every read return with the queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (rdy_w[i] && r_val[i]) begin
          if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got req %0d expected none at %0t", i, $time);
          end else begin
            g_t g;
            g = gq.pop_front();
            chk("grant_req", i, g.req);
            chk("grant_addr", {24'd0, mem_if.addr}, {24'd0, g.addr});
            chk("grant_wen", {31'd0, mem_if.wen}, {31'd0, g.wen});
          end
        end
      end
      if (rd_vld != '0) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_vld: got %b expected 000 at %0t", rd_vld, $time);
        end else begin
          r_t r;
          r = rq.pop_front();
          chk("rd_vld", {29'd0, rd_vld}, {29'd0, r.vld});
          for (int i = 0; i < N; i++)
            if (r.vld[i]) chk("rdata", {16'd0, rdata_w[i]}, {16'd0, r.data});
        end
      end
    end
  end

  function automatic bit busy();
    busy = (gq.size() != 0) || (rq.size() != 0);
    for (int i = 0; i < N; i++) if (pos[i] < cnt[i]) busy = 1'b1;
  endfunction

  task automatic drain();
    int t = 0;
    while (busy() && t < 300) begin @(negedge clk); t++; end
    chk("drain_timeout", {31'd0, t < 300}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Release reset and check the quiet window and first grant in cycle 256.
  task automatic init_window(input int r);
    int bad = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (rdy_w != '0 || mem_if.val) bad++;
      if (c == 255) chk("init_done_at_255", {31'd0, init_done}, 32'd0);
    end
    chk("init_quiet", bad, 0);
    @(negedge clk);
    chk("init_done_at_256", {31'd0, init_done}, 32'd1);
    chk("first_grant_256", {31'd0, rdy_w[r]}, 32'd1);
  endtask

  initial begin
    int bad;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {29'd0, rdy_w}, 32'd0);
    chk("rst_rd_vld", {29'd0, rd_vld}, 32'd0);
    chk("rst_mem_val", {31'd0, mem_if.val}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);

    // Init window with requester 0 waiting.
    push_op(0, 8'h10, 16'h0, 1'b0, 1'b0);
    exp_g(0, 8'h10, 1'b0); exp_r(3'b001, 16'h0000);
    init_window(0);
    drain();

    // Write then read back by requester 1.
    push_op(1, 8'h20, 16'hBEEF, 1'b1, 1'b0);
    push_op(1, 8'h20, 16'h0, 1'b0, 1'b0);
    exp_g(1, 8'h20, 1'b1); exp_g(1, 8'h20, 1'b0); exp_r(3'b010, 16'hBEEF);
    drain();

    // Requester 2 writes so the pointer sits at 2.
    push_op(2, 8'h30, 16'h1234, 1'b1, 1'b0);
    exp_g(2, 8'h30, 1'b1);
    drain();

    // Round robin, back-to-back reads from all three.
    push_op(0, 8'h20, 16'h0, 1'b0, 1'b0); push_op(0, 8'h30, 16'h0, 1'b0, 1'b0);
    push_op(1, 8'h30, 16'h0, 1'b0, 1'b0); push_op(1, 8'h20, 16'h0, 1'b0, 1'b0);
    push_op(2, 8'h10, 16'h0, 1'b0, 1'b0); push_op(2, 8'h30, 16'h0, 1'b0, 1'b0);
    exp_g(0, 8'h20, 1'b0); exp_g(1, 8'h30, 1'b0); exp_g(2, 8'h10, 1'b0);
    exp_g(0, 8'h30, 1'b0); exp_g(1, 8'h20, 1'b0); exp_g(2, 8'h30, 1'b0);
    exp_r(3'b001, 16'hBEEF); exp_r(3'b010, 16'h1234); exp_r(3'b100, 16'h0000);
    exp_r(3'b001, 16'h1234); exp_r(3'b010, 16'hBEEF); exp_r(3'b100, 16'h1234);
    drain();

    // Requester 1 writes so the pointer sits at 1 and req 2 wins next.
    push_op(1, 8'h40, 16'h5A5A, 1'b1, 1'b0);
    exp_g(1, 8'h40, 1'b1);
    drain();

    // Lock: req 2 locked read + write back-to-back despite 0 and 1 waiting.
    push_op(2, 8'h05, 16'h0, 1'b0, 1'b1);
    push_op(2, 8'h05, 16'h0001, 1'b1, 1'b0);
    push_op(0, 8'h05, 16'h0, 1'b0, 1'b0);
    push_op(1, 8'h40, 16'h0, 1'b0, 1'b0);
    exp_g(2, 8'h05, 1'b0); exp_g(2, 8'h05, 1'b1); exp_g(0, 8'h05, 1'b0); exp_g(1, 8'h40, 1'b0);
    exp_r(3'b100, 16'h0000); exp_r(3'b001, 16'h0001); exp_r(3'b010, 16'h5A5A);
    drain();

    // Memory backpressure for 3 cycles with reqs 0 and 1 pending.
    m_rdy = 1'b0;
    push_op(0, 8'h20, 16'h0, 1'b0, 1'b0);
    push_op(1, 8'h30, 16'h0, 1'b0, 1'b0);
    exp_g(0, 8'h20, 1'b0); exp_g(1, 8'h30, 1'b0);
    exp_r(3'b001, 16'hBEEF); exp_r(3'b010, 16'h1234);
    @(posedge clk);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy_w != '0) bad++;
    end
    chk("stall_no_rdy", bad, 0);
    chk("stall_mem_val", {31'd0, mem_if.val}, 32'd1);
    chk("stall_addr_req0", {24'd0, mem_if.addr}, 32'h20);
    @(posedge clk); #2 m_rdy = 1'b1;
    drain();

    // Reset in the cycle after a read acceptance drops the return.
    push_op(0, 8'h20, 16'h0, 1'b0, 1'b0);
    exp_g(0, 8'h20, 1'b0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(rdy_w[0] && r_val[0]) && t < 50);
    chk("mid_rst_accept_seen", {31'd0, t < 50}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_vld", {29'd0, rd_vld}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_mem_val", {31'd0, mem_if.val}, 32'd0);
    push_op(1, 8'h20, 16'h0, 1'b0, 1'b0);
    exp_g(1, 8'h20, 1'b0); exp_r(3'b010, 16'h0000);
    init_window(1);
    drain();

    chk("grant_queue_empty", gq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
